lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-002 rst_i  in  1  reset, synchronous, active-high.
REQ-003 lsu_req_i  in  1  memory operation request from issue (issue data_req_o).
REQ-004 lsu_we_i  in  1  1=store, 0=load (issue data_we_o).
REQ-005 lsu_type_i  in  2  access size: 00 word, 01 half, 10 byte, 11 reserved (treated as word).
REQ-006 lsu_sign_ext_i  in  1  load result sign-extended when 1, zero-extended when 0.
REQ-007 lsu_addr_i  in  32  byte address (ALU result).
REQ-008 lsu_wdata_i  in  32  store data (issue lsu_wdata_o), LSB-aligned.
REQ-009 rf_waddr_i  in  5  destination register of a load.
REQ-010 lsu_busy_o  out  1  operation in flight; new requests are not accepted.
REQ-011 data_req_o / data_we_o  out  1 / 1  bus request and write enable.
REQ-012 data_addr_o  out  32  word-aligned bus address.
REQ-013 data_be_o  out  4  byte enables.
REQ-014 data_wdata_o  out  32  bus write data.
REQ-015 data_gnt_i / data_rvalid_i / data_err_i  in  1 each  grant, response valid, bus error (err sampled with rvalid).
REQ-016 data_rdata_i  in  32  bus read data, valid with rvalid.
REQ-017 rf_we_o / rf_waddr_o / rf_wdata_o  out  1 / 5 / 32  load writeback to register file.
REQ-018 lsu_done_o / lsu_err_o  out  1 / 1  one-cycle completion pulse; error flag qualified by done.

Function
REQ-019 FSM states IDLE, WAIT_GNT, WAIT_RVALID, ERR; lsu_busy_o=1 in every state except IDLE.
REQ-020 In IDLE with lsu_req_i=1 (cycle N): op, size, sign, address, wdata and rf_waddr are registered; lsu_req_i in any other state is ignored.
REQ-021 Misaligned access (half with addr[0]=1; word with addr[1:0]!=0): transition to ERR, no bus request; in N+1 lsu_done_o=1, lsu_err_o=1, rf_we_o=0; return to IDLE in N+2.
REQ-022 Aligned access: transition to WAIT_GNT; data_req_o=1 from N+1, held with stable addr/we/be/wdata until the cycle data_gnt_i=1.
REQ-023 data_addr_o={addr[31:2],2'b00}; data_be_o: word 1111, half 0011<<addr[1]*2, byte 0001<<addr[1:0].
REQ-024 data_wdata_o: word as-is; half {2{wdata[15:0]}}; byte {4{wdata[7:0]}}.
REQ-025 data_gnt_i=1 in WAIT_GNT: transition to WAIT_RVALID; data_req_o=0 the following cycle.
REQ-026 data_rvalid_i is ignored outside WAIT_RVALID; data_gnt_i is ignored outside WAIT_GNT.
REQ-027 data_rvalid_i=1 in WAIT_RVALID (cycle M): next cycle M+1 lsu_done_o=1, lsu_err_o=data_err_i, transition to IDLE.
REQ-028 Load without error: in M+1 rf_we_o=1 (0 if rf_waddr=0), rf_waddr_o=captured rf_waddr, rf_wdata_o=selected lane extended per lsu_sign_ext_i.
REQ-029 Lane selection: half lane = rdata[16*addr[1] +: 16]; byte lane = rdata[8*addr[1:0] +: 8]; word uses rdata unchanged.
REQ-030 Store, or any op with data_err_i=1: rf_we_o=0.
REQ-031 lsu_done_o, lsu_err_o and rf_we_o are single-cycle pulses; rf_wdata_o/rf_waddr_o hold their last value otherwise.
REQ-032 Back-to-back: a new request is accepted in IDLE during the cycle lsu_done_o is high (minimum 3 cycles per aligned access with same-cycle gnt).

Reset
REQ-033 With rst_i=1 at a clock edge: state=IDLE; data_req_o, data_we_o, lsu_busy_o, rf_we_o, lsu_done_o, lsu_err_o=0; data_addr_o, data_be_o, data_wdata_o, rf_waddr_o, rf_wdata_o=0.
REQ-034 Reset mid-operation aborts it: no done or rf write is generated for it; a later rvalid for the aborted access is ignored in IDLE.
REQ-035 rst_i takes priority over lsu_req_i and over all bus inputs in the same cycle.

Verification
REQ-036 Load word addr 0x100, gnt at N+1, rdata 0xDEADBEEF at N+2 -> data_addr_o 0x100, be 1111; N+3 rf_we_o=1, rf_wdata_o 0xDEADBEEF, done=1.
REQ-037 Load byte signed addr 0x103, rdata 0x80FF0000 -> be 1000, rf_wdata_o 0xFFFFFF80; unsigned -> 0x00000080.
REQ-038 Store half addr 0x202, wdata 0x1234ABCD, gnt delayed 3 cycles -> data_req_o held 3+ cycles, addr 0x200, be 1100, wdata 0xABCDABCD; done with rf_we_o=0.
REQ-039 Load word addr 0x101 -> no data_req_o; next cycle done=1, err=1, rf_we_o=0; busy low one cycle later.
REQ-040 Load with data_err_i=1 at rvalid -> done=1, err=1, rf_we_o=0; lsu_req_i while busy is dropped.
REQ-041 rst_i asserted in WAIT_RVALID, then rvalid -> outputs at reset values, no done, no rf write; next request completes normally.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: takes one memory request from issue, drives a single
// request/grant/rvalid data-bus transaction, and writes load results back
// to the register file with lane selection and sign/zero extension.
module lsu (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_type_i,
  input  logic        lsu_sign_ext_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [4:0]  rf_waddr_i,
  output logic        lsu_busy_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [31:0] data_addr_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  input  logic [31:0] data_rdata_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        lsu_done_o,
  output logic        lsu_err_o
);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_WAIT_GNT    = 2'd1,
    S_WAIT_RVALID = 2'd2,
    S_ERR         = 2'd3
  } state_t;

  localparam logic [1:0] T_HALF = 2'b01;
  localparam logic [1:0] T_BYTE = 2'b10;

  state_t      r_state;
  logic        r_we;
  logic [1:0]  r_type;
  logic        r_sext;
  logic [1:0]  r_off;
  logic [4:0]  r_rd;
  logic        w_misaligned;

  // Byte enables for the addressed lanes; reserved size behaves as word.
  function automatic logic [3:0] f_be(input logic [1:0] ty, input logic [1:0] off);
    logic [3:0] be;
    case (ty)
      T_HALF:  be = off[1] ? 4'b1100 : 4'b0011;
      T_BYTE:  be = 4'b0001 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated across lanes so the enabled bytes carry it.
  function automatic logic [31:0] f_wdata(input logic [1:0] ty, input logic [31:0] wd);
    logic [31:0] d;
    case (ty)
      T_HALF:  d = {2{wd[15:0]}};
      T_BYTE:  d = {4{wd[7:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  // Pick the addressed lane out of the bus word and extend it to 32 bits.
  function automatic logic [31:0] f_load(input logic [1:0] ty, input logic sx,
                                         input logic [1:0] off, input logic [31:0] rd);
    logic signed [15:0] h;
    logic signed [7:0]  b;
    logic [31:0]        res;
    h = $signed(rd[16*off[1] +: 16]);
    b = $signed(rd[8*off +: 8]);
    case (ty)
      T_HALF:  res = sx ? 32'(h) : {16'h0000, h};
      T_BYTE:  res = sx ? 32'(b) : {24'h000000, b};
      default: res = rd;
    endcase
    return res;
  endfunction

  assign w_misaligned = (lsu_type_i == T_HALF) ? lsu_addr_i[0]
                      : (lsu_type_i == T_BYTE) ? 1'b0
                      : (lsu_addr_i[1:0] != 2'b00);

  // Capture the operation attributes needed later for writeback.
  always_ff @(posedge clk_i) begin
    if (r_state == S_IDLE && lsu_req_i) begin
      r_we   <= lsu_we_i;
      r_type <= lsu_type_i;
      r_sext <= lsu_sign_ext_i;
      r_off  <= lsu_addr_i[1:0];
      r_rd   <= rf_waddr_i;
    end
  end

  // Control FSM with all outputs registered; done/err/rf_we are one-cycle pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      lsu_busy_o   <= 1'b0;
      data_req_o   <= 1'b0;
      data_we_o    <= 1'b0;
      data_addr_o  <= 32'h0;
      data_be_o    <= 4'h0;
      data_wdata_o <= 32'h0;
      rf_we_o      <= 1'b0;
      rf_waddr_o   <= 5'h0;
      rf_wdata_o   <= 32'h0;
      lsu_done_o   <= 1'b0;
      lsu_err_o    <= 1'b0;
    end else begin
      lsu_done_o <= 1'b0;
      lsu_err_o  <= 1'b0;
      rf_we_o    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (lsu_req_i) begin
            lsu_busy_o <= 1'b1;
            if (w_misaligned) begin
              // Misaligned: report the error next cycle without touching the bus.
              r_state    <= S_ERR;
              lsu_done_o <= 1'b1;
              lsu_err_o  <= 1'b1;
            end else begin
              r_state      <= S_WAIT_GNT;
              data_req_o   <= 1'b1;
              data_we_o    <= lsu_we_i;
              data_addr_o  <= {lsu_addr_i[31:2], 2'b00};
              data_be_o    <= f_be(lsu_type_i, lsu_addr_i[1:0]);
              data_wdata_o <= f_wdata(lsu_type_i, lsu_wdata_i);
            end
          end
        end
        S_WAIT_GNT: begin
          if (data_gnt_i) begin
            r_state    <= S_WAIT_RVALID;
            data_req_o <= 1'b0;
            data_we_o  <= 1'b0;
          end
        end
        S_WAIT_RVALID: begin
          if (data_rvalid_i) begin
            r_state    <= S_IDLE;
            lsu_busy_o <= 1'b0;
            lsu_done_o <= 1'b1;
            lsu_err_o  <= data_err_i;
            if (!r_we && !data_err_i) begin
              rf_we_o    <= (r_rd != 5'd0);
              rf_waddr_o <= r_rd;
              rf_wdata_o <= f_load(r_type, r_sext, r_off, data_rdata_i);
            end
          end
        end
        S_ERR: begin
          r_state    <= S_IDLE;
          lsu_busy_o <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: drives load/store operations with a simple bus responder,
// queues the expected completion per operation and compares it when done fires.
module tb_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        lsu_req_i, lsu_we_i, lsu_sign_ext_i;
  logic [1:0]  lsu_type_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic [4:0]  rf_waddr_i;
  logic        lsu_busy_o, data_req_o, data_we_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic [3:0]  data_be_o;
  logic        data_gnt_i, data_rvalid_i, data_err_i;
  logic [31:0] data_rdata_i;
  logic        rf_we_o, lsu_done_o, lsu_err_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        err;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];

  lsu dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_type_i(lsu_type_i),
    .lsu_sign_ext_i(lsu_sign_ext_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .rf_waddr_i(rf_waddr_i), .lsu_busy_o(lsu_busy_o),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_addr_o(data_addr_o),
    .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i),
    .data_rdata_i(data_rdata_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .lsu_done_o(lsu_done_o), .lsu_err_o(lsu_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ld_model(input logic [1:0] ty, input logic sx,
                                           input logic [1:0] off, input logic [31:0] rd);
    logic [31:0] sh, m, r;
    case (ty)
      2'b10:   begin sh = rd >> (8 * off);     m = 32'h0000_00FF; end
      2'b01:   begin sh = rd >> (16 * off[1]); m = 32'h0000_FFFF; end
      default: begin sh = rd;                  m = 32'hFFFF_FFFF; end
    endcase
    r = sh & m;
    if (sx && ((r & (m ^ (m >> 1))) != 0)) r = r | ~m;
    return r;
  endfunction

  // Completion monitor: every done must match the oldest queued expectation.
  always @(negedge clk_i) begin
    exp_t e;
    if (lsu_done_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(lsu_done_o), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("done_err", 32'(lsu_err_o), 32'(e.err));
        chk("rf_we", 32'(rf_we_o), 32'(e.we));
        if (e.we) begin
          chk("rf_waddr", 32'(rf_waddr_o), 32'(e.waddr));
          chk("rf_wdata", rf_wdata_o, e.wdata);
        end
      end
    end else if (rf_we_o === 1'b1) begin
      chk("rf_we_without_done", 32'(rf_we_o), 32'd0);
    end
  end

  task automatic do_op(input logic we, input logic [1:0] ty, input logic sx,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] wa,
                       input int gdly, input logic [31:0] rd, input logic berr, input logic noise);
    exp_t        e;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] bwd;
    mis = (ty == 2'b01) ? addr[0] : (ty == 2'b10) ? 1'b0 : (addr[1:0] != 2'b00);
    case (ty)
      2'b01:   begin be = addr[1] ? 4'b1100 : 4'b0011; bwd = {wd[15:0], wd[15:0]}; end
      2'b10:   begin be = 4'b0001 << addr[1:0]; bwd = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]}; end
      default: begin be = 4'b1111; bwd = wd; end
    endcase
    e.err   = mis | berr;
    e.we    = !we && !mis && !berr && (wa != 5'd0);
    e.waddr = wa;
    e.wdata = ld_model(ty, sx, addr[1:0], rd);
    sb.push_back(e);
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_type_i = ty; lsu_sign_ext_i = sx;
    lsu_addr_i = addr; lsu_wdata_i = wd; rf_waddr_i = wa;
    @(negedge clk_i);
    lsu_req_i = 1'b0;
    chk("busy_hi", 32'(lsu_busy_o), 32'd1);
    if (mis) begin
      chk("mis_no_req", 32'(data_req_o), 32'd0);
      @(negedge clk_i);
      chk("mis_busy_lo", 32'(lsu_busy_o), 32'd0);
    end else begin
      if (noise) begin
        // Requests and stray responses while busy must be ignored.
        lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_type_i = 2'b00;
        lsu_addr_i = 32'h3; lsu_wdata_i = 32'hFFFF_FFFF; rf_waddr_i = 5'd31;
        data_rvalid_i = 1'b1; data_err_i = 1'b1;
      end
      for (int i = 0; i <= gdly; i++) begin
        chk("bus_req", 32'(data_req_o), 32'd1);
        chk("bus_addr", data_addr_o, {addr[31:2], 2'b00});
        chk("bus_be", 32'(data_be_o), 32'(be));
        chk("bus_wdata", data_wdata_o, bwd);
        chk("bus_we", 32'(data_we_o), 32'(we));
        if (i == gdly) data_gnt_i = 1'b1;
        @(negedge clk_i);
      end
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
      chk("req_drop", 32'(data_req_o), 32'd0);
      data_rvalid_i = 1'b1; data_rdata_i = rd; data_err_i = berr; data_gnt_i = noise;
      @(negedge clk_i);
      data_rvalid_i = 1'b0; data_err_i = 1'b0; data_gnt_i = 1'b0; lsu_req_i = 1'b0;
      chk("busy_lo", 32'(lsu_busy_o), 32'd0);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(lsu_busy_o), 32'd0);
    chk({tag, "_req"}, 32'(data_req_o), 32'd0);
    chk({tag, "_we"}, 32'(data_we_o), 32'd0);
    chk({tag, "_addr"}, data_addr_o, 32'd0);
    chk({tag, "_be"}, 32'(data_be_o), 32'd0);
    chk({tag, "_wdata"}, data_wdata_o, 32'd0);
    chk({tag, "_rfwe"}, 32'(rf_we_o), 32'd0);
    chk({tag, "_rfwaddr"}, 32'(rf_waddr_o), 32'd0);
    chk({tag, "_rfwdata"}, rf_wdata_o, 32'd0);
    chk({tag, "_done"}, 32'(lsu_done_o), 32'd0);
    chk({tag, "_err"}, 32'(lsu_err_o), 32'd0);
  endtask

  initial begin
    rst_i = 1'b1; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_type_i = 2'b00;
    lsu_sign_ext_i = 1'b0; lsu_addr_i = 32'h0; lsu_wdata_i = 32'h0; rf_waddr_i = 5'd0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = 32'h0;
    repeat (3) @(negedge clk_i);
    chk_reset_vals("rst");
    rst_i = 1'b0;
    @(negedge clk_i);

    // Directed cases: word load, byte loads, delayed-grant half store, misaligned, bus error.
    do_op(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 5'd5, 0, 32'hDEADBEEF, 1'b0, 1'b0);
    do_op(1'b0, 2'b10, 1'b1, 32'h103, 32'h0, 5'd6, 0, 32'h80FF0000, 1'b0, 1'b0);
    do_op(1'b0, 2'b10, 1'b0, 32'h103, 32'h0, 5'd7, 1, 32'h80FF0000, 1'b0, 1'b0);
    do_op(1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 5'd8, 3, 32'h0, 1'b0, 1'b0);
    do_op(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 5'd9, 0, 32'h0, 1'b0, 1'b0);
    do_op(1'b0, 2'b00, 1'b0, 32'h104, 32'h0, 5'd10, 1, 32'h12345678, 1'b1, 1'b1);
    do_op(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 5'd11, 0, 32'h80017FFF, 1'b0, 1'b1);
    do_op(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 5'd12, 0, 32'h80017FFF, 1'b0, 1'b0);
    do_op(1'b0, 2'b11, 1'b1, 32'h108, 32'h0, 5'd13, 0, 32'hCAFEF00D, 1'b0, 1'b0);
    do_op(1'b0, 2'b10, 1'b1, 32'h101, 32'h0, 5'd0, 0, 32'h0000FF00, 1'b0, 1'b0);
    do_op(1'b1, 2'b10, 1'b0, 32'h201, 32'h000000A5, 5'd14, 2, 32'h0, 1'b0, 1'b1);
    do_op(1'b1, 2'b01, 1'b0, 32'h105, 32'hFFFF0000, 5'd15, 0, 32'h0, 1'b0, 1'b0);
    do_op(1'b1, 2'b00, 1'b0, 32'h300, 32'h5A5A0F0F, 5'd16, 0, 32'h0, 1'b1, 1'b0);

    // Reset while waiting for rvalid, with a request in the reset cycle.
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_type_i = 2'b00; lsu_sign_ext_i = 1'b0;
    lsu_addr_i = 32'h400; rf_waddr_i = 5'd3;
    @(negedge clk_i);
    lsu_req_i = 1'b0; data_gnt_i = 1'b1;
    @(negedge clk_i);
    data_gnt_i = 1'b0; rst_i = 1'b1; lsu_req_i = 1'b1; data_rvalid_i = 1'b1;
    data_rdata_i = 32'h11111111;
    @(negedge clk_i);
    chk_reset_vals("midrst");
    rst_i = 1'b0; lsu_req_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'h22222222;
    @(negedge clk_i);
    data_rvalid_i = 1'b0;
    chk("late_rvalid_done", 32'(lsu_done_o), 32'd0);
    chk("late_rvalid_rfwe", 32'(rf_we_o), 32'd0);
    chk("late_rvalid_busy", 32'(lsu_busy_o), 32'd0);
    do_op(1'b0, 2'b00, 1'b0, 32'h404, 32'h0, 5'd4, 0, 32'h0BADF00D, 1'b0, 1'b0);

    // Randomised mix, back-to-back.
    for (int k = 0; k < 24; k++) begin
      do_op(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom),
            int'($urandom_range(0, 2)), $urandom, ($urandom_range(0, 7) == 0), 1'($urandom));
    end

    repeat (2) @(negedge clk_i);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
